// File: rtl/chunk_adder_pkg.sv
// ---------------------------------------------------------------------------
// chunk_adder_pkg
// Definitions shared by chunk_adder and its testbench:
//   state_e   - FSM state encoding (IDLE, RUN, DONE)
//   calc_nch  - number of chunk steps per operation (WIDTH / CHUNK)
//   cnt_width - chunk counter width: clog2 of the step count, at least 1 bit
// ---------------------------------------------------------------------------
package chunk_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int calc_nch(input int width, input int chunk);
        return width / chunk;
    endfunction

    // A single-step operation still needs a 1-bit counter so that the
    // vector declaration stays legal.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/chunk_adder_fa_chain.sv
// ---------------------------------------------------------------------------
// chunk_fa_chain
// Combinational CHUNK-bit ripple-carry adder built from xor/and/or
// full-adder cells.
// Ports:
//   a, b  [CHUNK-1:0]  addend slices
//   cin                carry into bit 0
//   s     [CHUNK-1:0]  sum slice
//   cout               carry out of the top bit
//   cmsb               carry into the top bit (signed-overflow detection)
// ---------------------------------------------------------------------------
module chunk_fa_chain #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             cmsb
);

    logic [CHUNK:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_cell
        logic p;
        assign p        = a[i] ^ b[i];
        assign s[i]     = p ^ c[i];
        assign c[i+1]   = (a[i] & b[i]) | (p & c[i]);
    end

    assign cout = c[CHUNK];
    assign cmsb = c[CHUNK-1];

endmodule

// File: rtl/chunk_adder.sv
// ---------------------------------------------------------------------------
// chunk_adder
// Multi-cycle adder/subtractor: processes CHUNK bits per clock through a
// chunk_fa_chain, WIDTH/CHUNK steps per operation, with a start/busy/done
// handshake.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               request an operation (accepted when not running)
//   sub                 0: a + b + ci, 1: a - b
//   a, b [WIDTH-1:0]    operands, sampled with an accepted start
//   ci                  carry-in for add, sampled with an accepted start
//   busy                operation in progress
//   done                one-cycle pulse, sum/co/ovf valid
//   sum [WIDTH-1:0]     result, held until the next operation completes
//   co                  carry out of the MSB (not-borrow for sub)
//   ovf                 signed overflow
// ---------------------------------------------------------------------------
module chunk_adder
    import chunk_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ovf
);

    localparam int NCH = calc_nch(WIDTH, CHUNK);
    localparam int CW  = cnt_width(NCH);

    if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_param_check
        $fatal(1, "chunk_adder: WIDTH must be a non-zero multiple of CHUNK");
    end

    state_e           state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic [CHUNK-1:0] part_sum;
    logic             part_cout;
    logic             part_cmsb;
    logic [WIDTH-1:0] res_next;

    chunk_fa_chain #(.CHUNK(CHUNK)) u_chain (
        .a    (a_r[CHUNK-1:0]),
        .b    (b_r[CHUNK-1:0]),
        .cin  (carry),
        .s    (part_sum),
        .cout (part_cout),
        .cmsb (part_cmsb)
    );

    // The newest partial sum enters at the top; after NCH steps the first
    // (least significant) chunk has been pushed down to bit 0. Written as
    // shifts so the CHUNK == WIDTH build needs no empty slice.
    assign res_next = (WIDTH'(part_sum) << (WIDTH - CHUNK)) | (res >> CHUNK);

    // NOTE: every register in this block uses non-blocking assignments so
    // each branch sees the pre-edge values of all state, regardless of order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            a_r   <= '0;
            b_r   <= '0;
            res   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            co    <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    a_r   <= a_r >> CHUNK;
                    b_r   <= b_r >> CHUNK;
                    res   <= res_next;
                    carry <= part_cout;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CW'(NCH - 1)) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        sum   <= res_next;
                        co    <= part_cout;
                        ovf   <= part_cout ^ part_cmsb;
                    end
                end
                // IDLE and DONE both accept a new start; DONE otherwise
                // falls back to IDLE after its single cycle.
                default: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= ST_RUN;
                        busy  <= 1'b1;
                        a_r   <= a;
                        b_r   <= sub ? ~b : b;
                        carry <= sub ? 1'b1 : ci;
                        cnt   <= '0;
                        res   <= '0;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule
